// File: rtl/pc_pkg.sv
// Shared constants and encodings for the program counter unit.
package pc_pkg;

  localparam int          PC_XLEN     = 32;
  localparam logic [31:0] PC_RST_VEC  = 32'h0000_0000;
  localparam logic [31:0] PC_TRAP_VEC = 32'h0000_0100;
  localparam int          PC_INC      = 4;

  // One-level trap state machine.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } pc_state_e;

  // Source of the next PC, already resolved by priority.
  typedef enum logic [2:0] {
    SEL_TRAP = 3'd0,
    SEL_EPC  = 3'd1,
    SEL_RAS  = 3'd2,
    SEL_DST  = 3'd3,
    SEL_HOLD = 3'd4,
    SEL_SEQ  = 3'd5
  } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer with a top pointer and a valid count.
// When full, a push overwrites the oldest entry, which is always the slot just
// above the top pointer.
module pc_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [XLEN-1:0]                din,
  output logic [XLEN-1:0]                top,
  output logic [$clog2(RAS_DEPTH+1)-1:0] cnt,
  output logic                           ovf,
  output logic                           unf
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0]   r_ptr;
  logic [CW-1:0]   r_cnt;
  logic            r_ovf;
  logic            r_unf;

  logic            w_full;
  logic            w_empty;
  logic [PW-1:0]   w_wr_ptr;

  assign w_full   = (r_cnt == CW'(RAS_DEPTH));
  assign w_empty  = (r_cnt == '0);
  assign w_wr_ptr = r_ptr + PW'(1);

  // Stack storage, pointer, count and the overflow/underflow pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_ptr <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= push && w_full;
      r_unf <= pop && w_empty;
      if (push) begin
        r_mem[w_wr_ptr] <= din;
        r_ptr           <= w_wr_ptr;
        if (!w_full) begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else if (pop && !w_empty) begin
        r_ptr <= r_ptr - PW'(1);
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  assign top = r_mem[r_ptr];
  assign cnt = r_cnt;
  assign ovf = r_ovf;
  assign unf = r_unf;

endmodule

// File: rtl/pc_unit.sv
// Program counter: sequential fetch, redirects, RAS call/return prediction and
// one-level trap entry/return. Every output is a register.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN      = PC_XLEN,
  parameter logic [XLEN-1:0] RST_VEC   = XLEN'(PC_RST_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(PC_TRAP_VEC),
  parameter int              INC       = PC_INC,
  parameter int              RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall,
  input  logic                           jmp,
  input  logic [XLEN-1:0]                dst,
  input  logic                           call,
  input  logic                           ret,
  input  logic                           trap,
  input  logic                           mret,
  output logic [XLEN-1:0]                val,
  output logic [XLEN-1:0]                epc,
  output logic                           in_trap,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_cnt,
  output logic                           ras_ovf,
  output logic                           ras_unf,
  output logic                           misal
);

  logic [XLEN-1:0] r_val;
  logic [XLEN-1:0] r_epc;
  pc_state_e       r_state;
  logic            r_misal;

  pc_sel_e         w_sel;
  logic            w_mis;
  logic            w_push;
  logic            w_pop;
  logic [XLEN-1:0] w_top;
  logic [XLEN-1:0] w_seq;

  assign w_mis = jmp && (dst[1:0] != 2'b00);
  assign w_seq = r_val + XLEN'(INC);

  // Resolve the redirect source by priority; RAS push/pop follow the winner.
  always_comb begin
    w_sel  = SEL_SEQ;
    w_push = 1'b0;
    w_pop  = 1'b0;
    if (trap || w_mis) begin
      w_sel = SEL_TRAP;
    end else if (mret && (r_state == ST_TRAP)) begin
      w_sel = SEL_EPC;
    end else if (ret) begin
      // Pop is requested even when empty so the stack reports the underflow.
      w_pop = 1'b1;
      w_sel = (ras_cnt != '0) ? SEL_RAS : SEL_DST;
    end else if (jmp) begin
      w_sel  = SEL_DST;
      w_push = call;
    end else if (stall) begin
      w_sel = SEL_HOLD;
    end
  end

  // PC, exception PC and trap state machine with the misalignment pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_val   <= RST_VEC;
      r_epc   <= '0;
      r_state <= ST_RUN;
      r_misal <= 1'b0;
    end else begin
      r_misal <= w_mis && !trap;
      case (w_sel)
        SEL_TRAP: begin
          r_val <= TRAP_VEC;
          // A nested trap keeps the original return point.
          if (r_state == ST_RUN) begin
            r_epc   <= r_val;
            r_state <= ST_TRAP;
          end
        end
        SEL_EPC: begin
          r_val   <= r_epc;
          r_state <= ST_RUN;
        end
        SEL_RAS:  r_val <= w_top;
        SEL_DST:  r_val <= dst;
        SEL_HOLD: r_val <= r_val;
        default:  r_val <= w_seq;
      endcase
    end
  end

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk  (clk),
    .rst  (rst),
    .push (w_push),
    .pop  (w_pop),
    .din  (w_seq),
    .top  (w_top),
    .cnt  (ras_cnt),
    .ovf  (ras_ovf),
    .unf  (ras_unf)
  );

  assign val     = r_val;
  assign epc     = r_epc;
  assign in_trap = (r_state == ST_TRAP);
  assign misal   = r_misal;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a behavioural model predicts every edge.
module tb_pc_unit;

  typedef struct {
    logic [31:0] val;
    logic [31:0] epc;
    logic        trp;
    logic [2:0]  cnt;
    logic        ovf;
    logic        unf;
    logic        mis;
  } exp_t;

  logic        clk = 1'b1;
  logic        rst;
  logic        stall, jmp, call, ret, trap, mret;
  logic [31:0] dst;
  logic [31:0] val, epc;
  logic        in_trap, ras_ovf, ras_unf, misal;
  logic [2:0]  ras_cnt;

  int n_pass  = 0;
  int n_total = 0;
  int n_txn   = 0;

  exp_t        sb[$];
  logic [31:0] m_ras[$];
  logic [31:0] m_val, m_epc;
  logic        m_trp;

  pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .jmp(jmp), .dst(dst), .call(call),
    .ret(ret), .trap(trap), .mret(mret), .val(val), .epc(epc),
    .in_trap(in_trap), .ras_cnt(ras_cnt), .ras_ovf(ras_ovf),
    .ras_unf(ras_unf), .misal(misal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_val = 32'h0;
    m_epc = 32'h0;
    m_trp = 1'b0;
    m_ras.delete();
  endtask

  // Drive one edge worth of inputs; predict, then compare after the edge.
  task automatic step(input logic st, input logic j, input logic [31:0] d,
                      input logic c, input logic r, input logic t, input logic m);
    exp_t e;
    exp_t g;
    logic mis;
    stall = st; jmp = j; dst = d; call = c; ret = r; trap = t; mret = m;
    mis = j && (d[1:0] != 2'b00);
    e.ovf = 1'b0; e.unf = 1'b0; e.mis = 1'b0;
    if (t || mis) begin
      e.mis = mis && !t;
      if (!m_trp) begin
        m_epc = m_val;
        m_trp = 1'b1;
      end
      m_val = 32'h100;
    end else if (m && m_trp) begin
      m_val = m_epc;
      m_trp = 1'b0;
    end else if (r) begin
      if (m_ras.size() > 0) m_val = m_ras.pop_back();
      else begin
        m_val = d;
        e.unf = 1'b1;
      end
    end else if (j) begin
      if (c) begin
        m_ras.push_back(m_val + 32'd4);
        if (m_ras.size() > 4) begin
          void'(m_ras.pop_front());
          e.ovf = 1'b1;
        end
      end
      m_val = d;
    end else if (!st) begin
      m_val = m_val + 32'd4;
    end
    e.val = m_val; e.epc = m_epc; e.trp = m_trp; e.cnt = 3'(m_ras.size());
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    n_txn++;
    $display("txn %0d st=%b j=%b c=%b r=%b t=%b m=%b dst=%h -> val=%h epc=%h trap=%b cnt=%0d",
             n_txn, st, j, c, r, t, m, d, val, epc, in_trap, ras_cnt);
    check("val", val, g.val);
    check("epc", epc, g.epc);
    check("in_trap", {31'b0, in_trap}, {31'b0, g.trp});
    check("ras_cnt", {29'b0, ras_cnt}, {29'b0, g.cnt});
    check("ras_ovf", {31'b0, ras_ovf}, {31'b0, g.ovf});
    check("ras_unf", {31'b0, ras_unf}, {31'b0, g.unf});
    check("misal", {31'b0, misal}, {31'b0, g.mis});
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    stall = 0; jmp = 0; dst = 0; call = 0; ret = 0; trap = 0; mret = 0;
    model_reset();
    #3;
    check("rst_val", val, 32'h0);
    check("rst_epc", epc, 32'h0);
    check("rst_trap", {31'b0, in_trap}, 32'h0);
    check("rst_cnt", {29'b0, ras_cnt}, 32'h0);
    #2 rst = 1'b0;

    // Free run, then stall versus jump.
    idle();
    idle();
    step(1, 1, 32'h40, 0, 0, 0, 0);
    step(1, 0, 32'h0, 0, 0, 0, 0);
    check("stall_hold", val, 32'h40);

    // Call / return / underflow.
    step(0, 1, 32'h10, 0, 0, 0, 0);
    step(0, 1, 32'h200, 1, 0, 0, 0);
    check("call_cnt", {29'b0, ras_cnt}, 32'd1);
    idle();
    step(0, 0, 32'h0, 0, 1, 0, 0);
    check("ret_val", val, 32'h14);
    step(0, 0, 32'h300, 0, 1, 0, 0);
    check("unf_val", val, 32'h300);
    idle();

    // Overflow: five calls, then four returns.
    for (int k = 1; k <= 5; k++) begin
      step(0, 1, 32'(k * 16), 0, 0, 0, 0);
      step(0, 1, 32'h1000, 1, 0, 0, 0);
    end
    check("ovf_pulse", {31'b0, ras_ovf}, 32'd1);
    step(0, 0, 32'h0, 0, 1, 0, 0);
    check("pop1", val, 32'h54);
    step(0, 0, 32'h0, 0, 1, 0, 0);
    check("pop2", val, 32'h44);
    step(0, 0, 32'h0, 0, 1, 0, 0);
    step(0, 0, 32'h0, 0, 1, 0, 0);
    check("pop4", val, 32'h24);

    // Trap nesting and mret in both states; trap overrides stall.
    step(0, 1, 32'h80, 0, 0, 0, 0);
    step(1, 0, 32'h0, 0, 0, 1, 0);
    check("trap_epc", epc, 32'h80);
    step(0, 0, 32'h0, 0, 0, 1, 0);
    step(0, 0, 32'h0, 0, 0, 0, 1);
    check("mret_val", val, 32'h80);
    step(0, 0, 32'h0, 0, 0, 0, 1);
    check("mret_run", val, 32'h84);

    // Sequential wrap.
    step(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    idle();
    check("wrap", val, 32'h0);

    // Misaligned call jump traps with no push.
    step(0, 1, 32'h20, 0, 0, 0, 0);
    step(0, 1, 32'h102, 1, 0, 0, 0);
    check("mis_epc", epc, 32'h20);

    // Asynchronous reset in the middle of a cycle while trapped.
    #2 rst = 1'b1;
    #1;
    check("async_val", val, 32'h0);
    check("async_trap", {31'b0, in_trap}, 32'h0);
    model_reset();
    #1 rst = 1'b0;
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
